// File: rtl/sm_cfg_write_sched_if.sv
// Request/flit bundle between requesters, the write scheduler and the
// config block.
interface sm_cfg_write_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][11:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_done;
  logic [17:0]              dii_flit_out;
  logic                     dii_flit_out_ready;
  logic                     cfg_irq;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output req_valid, req_addr, req_data,
    output dii_flit_out_ready, cfg_irq,
    input  req_ready, req_done, dii_flit_out,
    input  busy, timeout_err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    input  dii_flit_out_ready, cfg_irq,
    output req_ready, req_done, dii_flit_out,
    output busy, timeout_err
  );
endinterface

// File: rtl/sm_cfg_write_sched.sv
// Round-robin register-write scheduler: serialises each write into a
// three-flit DII packet, optionally holding until cfg_irq clears.
module sm_cfg_write_sched #(
  parameter int NUM_REQ     = 2,
  parameter int WAIT_IRQ    = 1,
  parameter int IRQ_TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  sm_cfg_write_sched_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(IRQ_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LOW, S_HIGH, S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_last;
  logic [GW-1:0] w_gnt;
  logic          w_gnt_vld;
  logic [11:0]   r_addr;
  logic [31:0]   r_data;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_take;
  logic          w_timeout;
  logic          w_cfg_addr;
  int            w_best;
  int            w_dist;

  assign w_cfg_addr = (r_addr >= 12'h300) &&
                      (r_addr <= 12'h4FF);

  // Smallest distance past last grant wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_last))
               % NUM_REQ;
      if (bus.req_valid[i] && w_dist < w_best) begin
        w_best    = w_dist;
        w_gnt_vld = 1'b1;
        w_gnt     = GW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_take           = 1'b0;
    w_timeout        = 1'b0;
    bus.req_ready    = '0;
    bus.req_done     = '0;
    bus.dii_flit_out = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld && rst_n) begin
          w_take        = 1'b1;
          bus.req_ready = NUM_REQ'(1) << w_gnt;
          w_next        = S_ADDR;
        end
      end
      S_ADDR: begin
        bus.dii_flit_out = {2'b10, 4'h0, r_addr};
        if (bus.dii_flit_out_ready) w_next = S_LOW;
      end
      S_LOW: begin
        bus.dii_flit_out = {2'b10, r_data[15:0]};
        if (bus.dii_flit_out_ready) w_next = S_HIGH;
      end
      S_HIGH: begin
        bus.dii_flit_out = {2'b11, r_data[31:16]};
        if (bus.dii_flit_out_ready) begin
          bus.req_done = NUM_REQ'(1) << r_last;
          if (WAIT_IRQ == 1 && w_cfg_addr)
            w_next = S_WAIT;
          else
            w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        // Dirty flag lands one cycle after last.
        if (r_cnt != '0 && !bus.cfg_irq) begin
          w_next = S_IDLE;
        end else if (r_cnt == CW'(IRQ_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= GW'(NUM_REQ - 1);
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_take) begin
        r_last <= w_gnt;
        r_addr <= bus.req_addr[w_gnt];
        r_data <= bus.req_data[w_gnt];
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_err;
endmodule

// File: tb/tb_sm_cfg_write_sched.sv
// Bench for sm_cfg_write_sched: vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sm_cfg_write_sched;
  localparam int N  = 3;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sm_cfg_write_sched_if #(.NUM_REQ(N)) ba();
  sm_cfg_write_sched_if #(.NUM_REQ(2)) bb();

  sm_cfg_write_sched #(
    .NUM_REQ(N), .WAIT_IRQ(1), .IRQ_TIMEOUT(TO)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ba.slave)
  );

  sm_cfg_write_sched #(
    .NUM_REQ(2), .WAIT_IRQ(0), .IRQ_TIMEOUT(1024)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bb.slave)
  );

  typedef struct {
    logic [N-1:0] v;
    bit           rdy;
    bit           irq;
    logic [N-1:0] er;
    logic [N-1:0] ed;
    logic [17:0]  ef;
    bit           eb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [N-1:0] v, bit rdy, bit irq,
                              logic [N-1:0] er, logic [N-1:0] ed,
                              logic [17:0] ef, bit eb);
    vec_t r;
    r.v = v; r.rdy = rdy; r.irq = irq;
    r.er = er; r.ed = ed; r.ef = ef; r.eb = eb;
    return r;
  endfunction

  function automatic logic [17:0] fl(bit l, logic [15:0] d);
    return {1'b1, l, d};
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [11:0] a,
                         input logic [31:0] d);
    ba.req_addr[i] = a;
    ba.req_data[i] = d;
  endtask

  // reference model state
  int          m_last;
  int          m_cur;
  bit          m_wait;
  int          m_wcnt;
  bit          m_err;
  logic [11:0] m_addr;
  logic [17:0] mq[$];

  int           gidx[$];
  int           gcyc[$];
  int           nd;
  int           dcyc;
  int           g;
  bit           irq_mode;
  bit           fr;
  bit           ir;
  logic [N-1:0] rv;
  logic [N-1:0] e_rdy;
  logic [N-1:0] e_done;
  logic [17:0]  e_flit;
  logic [17:0]  bp_exp;
  bit           e_busy;
  logic [11:0]  pool [8] = '{12'h200, 12'h2FF, 12'h300, 12'h304,
                             12'h4FF, 12'h500, 12'h0AB, 12'hFFF};

  initial begin
    ba.req_valid = '0; ba.req_addr = '0; ba.req_data = '0;
    ba.dii_flit_out_ready = 1'b1; ba.cfg_irq = 1'b0;
    bb.req_valid = '0; bb.req_addr = '0; bb.req_data = '0;
    bb.dii_flit_out_ready = 1'b1; bb.cfg_irq = 1'b0;

    set_req(0, 12'h304, 32'hDEAD_BEEF);
    set_req(1, 12'h200, 32'h1234_5678);
    set_req(2, 12'h4FF, 32'hCAFE_F00D);

    tbl.push_back(mk(3'b001, 1, 0, 3'b001, 0, 18'h0, 0));
    tbl.push_back(mk(3'b000, 1, 0, 0, 0, fl(0, 16'h0304), 1));
    tbl.push_back(mk(3'b000, 1, 0, 0, 0, fl(0, 16'hBEEF), 1));
    tbl.push_back(mk(3'b000, 1, 0, 0, 3'b001, fl(1, 16'hDEAD), 1));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(3'b000, 1, 1, 0, 0, 18'h0, 1));
    tbl.push_back(mk(3'b010, 1, 0, 0, 0, 18'h0, 1));
    tbl.push_back(mk(3'b010, 1, 0, 3'b010, 0, 18'h0, 0));
    tbl.push_back(mk(3'b000, 1, 0, 0, 0, fl(0, 16'h0200), 1));
    tbl.push_back(mk(3'b000, 1, 0, 0, 0, fl(0, 16'h5678), 1));
    tbl.push_back(mk(3'b000, 1, 0, 0, 3'b010, fl(1, 16'h1234), 1));
    tbl.push_back(mk(3'b000, 1, 0, 0, 0, 18'h0, 0));

    // outputs held at zero during reset
    ba.req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready", ba.req_ready, 0);
    chk("rst.done", ba.req_done, 0);
    chk("rst.flit", ba.dii_flit_out, 0);
    chk("rst.busy", ba.busy, 0);
    chk("rst.err", ba.timeout_err, 0);
    @(negedge clk);
    ba.req_valid = '0;
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      ba.req_valid = tbl[r].v;
      ba.dii_flit_out_ready = tbl[r].rdy;
      ba.cfg_irq = tbl[r].irq;
      #1;
      chk($sformatf("t%0d.ready", r), ba.req_ready, tbl[r].er);
      chk($sformatf("t%0d.done", r), ba.req_done, tbl[r].ed);
      chk($sformatf("t%0d.flit", r), ba.dii_flit_out, tbl[r].ef);
      chk($sformatf("t%0d.busy", r), ba.busy, tbl[r].eb);
    end

    // round robin, non-waiting address
    set_req(0, 12'h200, 32'h0000_0001);
    set_req(1, 12'h200, 32'h0000_0002);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ba.req_valid = 3'b011;
      ba.dii_flit_out_ready = 1'b1;
      ba.cfg_irq = 1'b0;
      #1;
      chk($sformatf("rr.onehot%0d", c),
          ($countones(ba.req_ready) <= 1), 1);
      if (ba.req_ready != 0) begin
        gcyc.push_back(c);
        gidx.push_back(oh_idx(ba.req_ready));
      end
    end
    chk("rr.count", gidx.size(), 4);
    for (int k = 0; k < gidx.size() && k < 4; k++) begin
      chk($sformatf("rr.idx%0d", k), gidx[k], k % 2);
      chk($sformatf("rr.cyc%0d", k), gcyc[k], 4 * k);
    end
    @(negedge clk);
    ba.req_valid = '0;
    repeat (2) @(negedge clk);

    // backpressure on the LOW flit
    set_req(2, 12'h200, 32'hA5A5_5A5A);
    nd = 0;
    dcyc = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ba.req_valid = (c == 0) ? 3'b100 : 3'b000;
      ba.dii_flit_out_ready = !(c >= 2 && c <= 4);
      #1;
      if (c == 0) chk("bp.grant", ba.req_ready, 3'b100);
      if (c == 1) bp_exp = fl(0, 16'h0200);
      else if (c >= 2 && c <= 5) bp_exp = fl(0, 16'h5A5A);
      else if (c == 6) bp_exp = fl(1, 16'hA5A5);
      else bp_exp = 18'h0;
      chk($sformatf("bp.flit%0d", c), ba.dii_flit_out, bp_exp);
      if (ba.req_done != 0) begin
        nd++;
        dcyc = c;
        chk("bp.done_id", ba.req_done, 3'b100);
      end
    end
    chk("bp.ndone", nd, 1);
    chk("bp.done_cyc", dcyc, 6);

    // IRQ wait timeout with irq stuck high
    set_req(0, 12'h400, 32'h0BAD_F00D);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 20) set_req(0, 12'h200, 32'h1111_2222);
      ba.req_valid = (c == 0 || c == 20) ? 3'b001 : 3'b000;
      ba.dii_flit_out_ready = 1'b1;
      ba.cfg_irq = 1'b1;
      #1;
      if (c == 0) chk("to.grant", ba.req_ready, 3'b001);
      if (c == 3) chk("to.high", ba.dii_flit_out, fl(1, 16'h0BAD));
      if (c == 10) chk("to.busy_mid", ba.busy, 1);
      if (c == 19) begin
        chk("to.busy19", ba.busy, 1);
        chk("to.err19", ba.timeout_err, 0);
      end
      if (c == 20) begin
        chk("to.err20", ba.timeout_err, 1);
        chk("to.busy20", ba.busy, 0);
        chk("to.regrant", ba.req_ready, 3'b001);
      end
      if (c == 24) chk("to.sticky", ba.timeout_err, 1);
    end

    // no wait when WAIT_IRQ is 0
    bb.req_addr[0] = 12'h300;
    bb.req_data[0] = 32'h5555_AAAA;
    bb.cfg_irq = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bb.req_valid = 2'b01;
      #1;
      chk($sformatf("nw.ready%0d", c), bb.req_ready,
          (c == 0 || c == 4) ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    bb.req_valid = '0;

    // async reset during HIGH flit
    ba.cfg_irq = 1'b0;
    set_req(1, 12'h200, 32'h3333_4444);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ba.req_valid = (c == 0) ? 3'b010 : 3'b000;
      ba.dii_flit_out_ready = 1'b1;
      #1;
      if (c == 0) chk("ar.grant", ba.req_ready, 3'b010);
    end
    chk("ar.pre_done", ba.req_done, 3'b010);
    ba.req_valid = 3'b011;
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.flit", ba.dii_flit_out, 0);
    chk("ar.done", ba.req_done, 0);
    chk("ar.ready", ba.req_ready, 0);
    chk("ar.busy", ba.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar.first", ba.req_ready, 3'b001);
    @(negedge clk);
    ba.req_valid = '0;
    repeat (5) @(negedge clk);

    // randomized traffic against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1; m_cur = 0; m_wait = 0;
    m_wcnt = 0; m_err = 0; m_addr = '0;
    mq.delete();
    irq_mode = 0;
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge clk);
      if (cy % 256 == 0) irq_mode = bit'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        rv[i] = ($urandom_range(0, 3) == 0);
        ba.req_addr[i] = pool[$urandom_range(0, 7)];
        ba.req_data[i] = $urandom;
      end
      ba.req_valid = rv;
      fr = ($urandom_range(0, 3) != 0);
      ir = irq_mode ? ($urandom_range(0, 39) != 0)
                    : ($urandom_range(0, 1) == 1);
      ba.dii_flit_out_ready = fr;
      ba.cfg_irq = ir;
      #1;
      e_rdy = '0; e_done = '0; e_flit = '0; e_busy = 0; g = -1;
      if (mq.size() > 0) begin
        e_flit = mq[0];
        e_busy = 1;
        if (mq.size() == 1 && fr) e_done[m_cur] = 1'b1;
      end else if (m_wait) begin
        e_busy = 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && rv[(m_last + k) % N]) g = (m_last + k) % N;
        end
        if (g >= 0) e_rdy[g] = 1'b1;
      end
      chk($sformatf("rnd%0d.ready", cy), ba.req_ready, e_rdy);
      chk($sformatf("rnd%0d.done", cy), ba.req_done, e_done);
      chk($sformatf("rnd%0d.flit", cy), ba.dii_flit_out, e_flit);
      chk($sformatf("rnd%0d.busy", cy), ba.busy, e_busy);
      chk($sformatf("rnd%0d.err", cy), ba.timeout_err, m_err);
      if (mq.size() > 0) begin
        if (fr) begin
          void'(mq.pop_front());
          if (mq.size() == 0 && m_addr >= 12'h300 &&
              m_addr <= 12'h4FF) begin
            m_wait = 1;
            m_wcnt = 0;
          end
        end
      end else if (m_wait) begin
        if (m_wcnt >= 1 && !ir) m_wait = 0;
        else if (m_wcnt == TO - 1) begin
          m_err = 1;
          m_wait = 0;
        end
        m_wcnt++;
      end else if (g >= 0) begin
        m_last = g;
        m_cur = g;
        m_addr = ba.req_addr[g];
        mq.push_back({2'b10, 4'h0, ba.req_addr[g]});
        mq.push_back({2'b10, ba.req_data[g][15:0]});
        mq.push_back({2'b11, ba.req_data[g][31:16]});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
